// File: rtl/sdes_hex_feeder.sv
// sdes_hex_feeder: holds the latest SDES plaintext/ciphertext bytes and feeds
// one byte as a nibble pair to the two 7-segment decoders. A fresh capture is
// flashed, then the display alternates between the two stored values.
module sdes_hex_feeder #(
  parameter int DWELL_CYCLES = 50000000,
  parameter int BLINK_CYCLES = 12500000,
  parameter int BLINKS       = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] pt_in,
  input  logic       pt_valid,
  input  logic [7:0] ct_in,
  input  logic       ct_valid,
  output logic [3:0] nib_hi,
  output logic [3:0] nib_lo,
  output logic       blank,
  output logic       sel_ct,
  output logic       flashing
);

  // The flash counter is kept as (phase index, cycle within phase) so the
  // on/off decision is just the phase LSB instead of a divide.
  localparam int PHASES = 2 * BLINKS;
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam int PW = $clog2(PHASES);
  localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);
  localparam logic [PW-1:0] PHASE_LAST = PW'(PHASES - 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {
    BLANK = 2'd0,
    FLASH = 2'd1,
    SHOW  = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [7:0]    pt_reg, ct_reg;
  logic          have_pt, have_ct;
  logic          sel_nxt;
  logic [BW-1:0] blink_cnt, blink_nxt;
  logic [PW-1:0] phase_cnt, phase_nxt;
  logic [DW-1:0] dwell_cnt, dwell_nxt;
  logic          capture;

  assign capture = pt_valid | ct_valid;

  // Capture registers: each strobe latches its byte and marks it present.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pt_reg  <= 8'h00;
      ct_reg  <= 8'h00;
      have_pt <= 1'b0;
      have_ct <= 1'b0;
    end else begin
      if (pt_valid) begin
        pt_reg  <= pt_in;
        have_pt <= 1'b1;
      end
      if (ct_valid) begin
        ct_reg  <= ct_in;
        have_ct <= 1'b1;
      end
    end
  end

  // Display state register, selection and flash/dwell counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= BLANK;
      sel_ct    <= 1'b0;
      blink_cnt <= '0;
      phase_cnt <= '0;
      dwell_cnt <= '0;
    end else begin
      state     <= state_nxt;
      sel_ct    <= sel_nxt;
      blink_cnt <= blink_nxt;
      phase_cnt <= phase_nxt;
      dwell_cnt <= dwell_nxt;
    end
  end

  // Next-state logic: a capture always wins and restarts the flash.
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel_ct;
    blink_nxt = blink_cnt;
    phase_nxt = phase_cnt;
    dwell_nxt = dwell_cnt;
    if (capture) begin
      state_nxt = FLASH;
      sel_nxt   = ct_valid;
      blink_nxt = '0;
      phase_nxt = '0;
    end else begin
      case (state)
        FLASH: begin
          if (blink_cnt == BLINK_LAST) begin
            blink_nxt = '0;
            if (phase_cnt == PHASE_LAST) begin
              state_nxt = SHOW;
              phase_nxt = '0;
              dwell_nxt = '0;
            end else begin
              phase_nxt = phase_cnt + 1'b1;
            end
          end else begin
            blink_nxt = blink_cnt + 1'b1;
          end
        end
        SHOW: begin
          if (dwell_cnt == DWELL_LAST) begin
            dwell_nxt = '0;
            // Only switch when the other value has actually been captured.
            if (sel_ct ? have_pt : have_ct) begin
              sel_nxt = ~sel_ct;
            end
          end else begin
            dwell_nxt = dwell_cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs decode registers only; odd flash phases are the dark ones.
  always_comb begin
    nib_hi   = sel_ct ? ct_reg[7:4] : pt_reg[7:4];
    nib_lo   = sel_ct ? ct_reg[3:0] : pt_reg[3:0];
    blank    = 1'b0;
    flashing = 1'b0;
    case (state)
      BLANK: blank = 1'b1;
      FLASH: begin
        flashing = 1'b1;
        blank    = phase_cnt[0];
      end
      default: begin
      end
    endcase
  end

endmodule
